// File: rtl/cordic_vector.sv
// rtl/cordic_vector.sv - iterative CORDIC vectoring engine, (x,y) -> magnitude and atan2 angle.
// Optional gain compensation stage when GAIN_COMP_EN is defined.

module cordic_atan_lut (
    input  logic [3:0]  count,
    output logic [17:0] atan
);
    // atan(2^-i) in Q2.16 radians, rounded to nearest
    always_comb begin
        case (count)
            4'd0:  atan = 18'd51472;
            4'd1:  atan = 18'd30386;
            4'd2:  atan = 18'd16055;
            4'd3:  atan = 18'd8150;
            4'd4:  atan = 18'd4091;
            4'd5:  atan = 18'd2047;
            4'd6:  atan = 18'd1024;
            4'd7:  atan = 18'd512;
            4'd8:  atan = 18'd256;
            4'd9:  atan = 18'd128;
            4'd10: atan = 18'd64;
            4'd11: atan = 18'd32;
            4'd12: atan = 18'd16;
            4'd13: atan = 18'd8;
            4'd14: atan = 18'd4;
            4'd15: atan = 18'd2;
        endcase
    end
endmodule

module cordic_vector #(
    parameter int DW   = 18,
    parameter int ITER = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] y_in,
    output logic                 busy,
    output logic                 done,
    output logic [DW+1:0]        mag_out,
    output logic signed [18:0]   angle_out
);
    localparam int XW = DW + 2;
    localparam logic signed [18:0] HALF_PI = 19'sd102944;

    typedef enum logic [1:0] {IDLE, ITERATE, COMP} state_t;

    state_t               state, state_nxt;
    logic signed [XW-1:0] x_r, y_r;
    logic signed [18:0]   z_r;
    logic [3:0]           cnt;
    logic [17:0]          atan;
    logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh, x_nxt, y_nxt;
    logic signed [18:0]   atan_z, z_nxt;
    logic                 last;

    cordic_atan_lut u_lut (
        .count (cnt),
        .atan  (atan)
    );

    // two guard bits keep the negation of the most negative input representable
    assign x_ext  = {{2{x_in[DW-1]}}, x_in};
    assign y_ext  = {{2{y_in[DW-1]}}, y_in};
    assign atan_z = {1'b0, atan};
    assign x_sh   = x_r >>> cnt;
    assign y_sh   = y_r >>> cnt;
    assign last   = (cnt == 4'(ITER - 1));

    always_comb begin
        x_nxt = x_r;
        y_nxt = y_r;
        z_nxt = z_r;
        if (!y_r[XW-1]) begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + atan_z;
        end else begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - atan_z;
        end
    end

`ifdef GAIN_COMP_EN
    localparam logic signed [16:0] INV_GAIN = 17'sd39797;
    logic signed [XW+16:0] gain_prod;
    assign gain_prod = x_r * INV_GAIN;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITERATE;
`ifdef GAIN_COMP_EN
            ITERATE: if (last) state_nxt = COMP;
`else
            ITERATE: if (last) state_nxt = IDLE;
`endif
            COMP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            mag_out   <= '0;
            angle_out <= '0;
            cnt       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        // quadrant pre-rotation brings the vector into the right half-plane
                        if (!x_in[DW-1]) begin
                            x_r <= x_ext;
                            y_r <= y_ext;
                            z_r <= '0;
                        end else if (!y_in[DW-1]) begin
                            x_r <= y_ext;
                            y_r <= -x_ext;
                            z_r <= HALF_PI;
                        end else begin
                            x_r <= -y_ext;
                            y_r <= x_ext;
                            z_r <= -HALF_PI;
                        end
                    end
                end
                ITERATE: begin
                    x_r <= x_nxt;
                    y_r <= y_nxt;
                    z_r <= z_nxt;
                    if (last) begin
                        cnt <= '0;
`ifndef GAIN_COMP_EN
                        mag_out   <= x_nxt;
                        angle_out <= z_nxt;
                        done      <= 1'b1;
                        busy      <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
`ifdef GAIN_COMP_EN
                COMP: begin
                    mag_out   <= gain_prod[XW+15:16];
                    angle_out <= z_r;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vector.sv
// tb/tb_cordic_vector.sv - self-checking bench for cordic_vector with a scoreboard of expected results.

module tb_cordic_vector;
    localparam int DW   = 18;
    localparam int ITER = 16;
`ifdef GAIN_COMP_EN
    localparam int LAT = ITER + 2;
`else
    localparam int LAT = ITER + 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [DW-1:0] x_in = '0;
    logic signed [DW-1:0] y_in = '0;
    logic                 busy;
    logic                 done;
    logic [DW+1:0]        mag_out;
    logic signed [18:0]   angle_out;

    typedef struct {
        int mag;
        int ang;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   atan_tab[16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                           256, 128, 64, 32, 16, 8, 4, 2};

    cordic_vector #(.DW(DW), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .busy      (busy),
        .done      (done),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int xv, input int yv);
        exp_t r;
        int x, y, z, xn, yn;
        if (xv >= 0)      begin x = xv;  y = yv;  z = 0;       end
        else if (yv >= 0) begin x = yv;  y = -xv; z = 102944;  end
        else              begin x = -yv; y = xv;  z = -102944; end
        for (int i = 0; i < ITER; i++) begin
            if (y >= 0) begin xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_tab[i]; end
            else        begin xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_tab[i]; end
            x = xn;
            y = yn;
        end
`ifdef GAIN_COMP_EN
        r.mag = int'((longint'(x) * 64'sd39797) >>> 16);
`else
        r.mag = x;
`endif
        r.ang = z;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected_done observed=done expected=no_done");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (int'(mag_out) === e.mag) else begin
                    errors++;
                    $error("FAIL sb_mag observed=%0d expected=%0d", int'(mag_out), e.mag);
                end
                checks++;
                assert (int'(angle_out) === e.ang) else begin
                    errors++;
                    $error("FAIL sb_angle observed=%0d expected=%0d", int'(angle_out), e.ang);
                end
            end
        end
    end

    // call at a negedge; returns just after the accept edge
    task automatic launch(input int xv, input int yv);
        x_in  = DW'(xv);
        y_in  = DW'(yv);
        start = 1'b1;
        exp_q.push_back(model(xv, yv));
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        assert (busy === 1'b1) else begin
            errors++;
            $error("FAIL busy_after_accept observed=%0b expected=1", busy);
        end
    endtask

    task automatic wait_done(input string tag, input int c0);
        int cyc;
        cyc = c0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 60);
        checks++;
        assert (cyc === LAT) else begin
            errors++;
            $error("FAIL latency_%s observed=%0d expected=%0d", tag, cyc, LAT);
        end
    endtask

    task automatic check_ideal(input string tag, input int imag, input int iang);
        int dm, da;
        dm = int'(mag_out) - imag;
        if (dm < 0) dm = -dm;
        da = int'(angle_out) - iang;
        if (da < 0) da = -da;
        checks++;
        assert ((dm <= imag / 1000) === 1'b1) else begin
            errors++;
            $error("FAIL ideal_mag_%s observed=%0d expected=%0d", tag, int'(mag_out), imag);
        end
        checks++;
        assert ((da <= 8) === 1'b1) else begin
            errors++;
            $error("FAIL ideal_angle_%s observed=%0d expected=%0d", tag, int'(angle_out), iang);
        end
    endtask

    task automatic run_op(input int xv, input int yv);
        launch(xv, yv);
        wait_done("op", 0);
    endtask

    initial begin
        int m1, m2, dc;
`ifdef GAIN_COMP_EN
        m1 = 65536;  m2 = 92682;
`else
        m1 = 107925; m2 = 152628;
`endif
        #1;
        checks++;
        assert ({busy, done} === 2'b00) else begin
            errors++;
            $error("FAIL reset_flags observed=%b expected=00", {busy, done});
        end
        checks++;
        assert (int'(mag_out) === 0) else begin
            errors++;
            $error("FAIL reset_mag observed=%0d expected=0", int'(mag_out));
        end
        checks++;
        assert (int'(angle_out) === 0) else begin
            errors++;
            $error("FAIL reset_angle observed=%0d expected=0", int'(angle_out));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(65536, 0);
        check_ideal("pos_x", m1, 0);
        run_op(0, 65536);
        check_ideal("pos_y", m1, 102944);
        run_op(-65536, 0);
        check_ideal("neg_x", m1, 205887);
        run_op(-65536, -65536);
        check_ideal("third_q", m2, -154415);

        run_op(0, 0);
        checks++;
        assert (int'(mag_out) === 0) else begin
            errors++;
            $error("FAIL zero_mag observed=%0d expected=0", int'(mag_out));
        end
        run_op(-131072, -131072);
        run_op(-131072, 131071);
        run_op(131071, -131072);

        // a start while busy must be ignored; a start on the done cycle must be taken
        dc = done_cnt;
        launch(30000, -20000);
        repeat (4) @(negedge clk);
        x_in  = DW'(-777);
        y_in  = DW'(999);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", 5);
        launch(-12345, 54321);
        wait_done("done_cycle_start", 0);
        checks++;
        assert (done_cnt - dc === 2) else begin
            errors++;
            $error("FAIL done_count observed=%0d expected=2", done_cnt - dc);
        end

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        launch(40000, 50000);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        dc = done_cnt;
        checks++;
        assert ({busy, done} === 2'b00) else begin
            errors++;
            $error("FAIL midop_reset_flags observed=%b expected=00", {busy, done});
        end
        checks++;
        assert (int'(mag_out) === 0 && int'(angle_out) === 0) else begin
            errors++;
            $error("FAIL midop_reset_outputs observed=%0d/%0d expected=0/0", int'(mag_out), int'(angle_out));
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        checks++;
        assert (done_cnt === dc) else begin
            errors++;
            $error("FAIL no_done_after_reset observed=%0d expected=%0d", done_cnt, dc);
        end
        run_op(65536, 0);
        check_ideal("after_reset", m1, 0);

        for (int k = 0; k < 6; k++) begin
            run_op(int'($urandom_range(0, 262143)) - 131072,
                   int'($urandom_range(0, 262143)) - 131072);
        end

        repeat (2) @(negedge clk);
        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
